spi_display_receiver: RTL and testbench



---
 rtl/spi_display_receiver_pkg.sv | 30 +++
 rtl/spi_display_receiver_input_sync.sv | 35 +++
 rtl/spi_display_receiver.sv | 209 ++++++++++++++++++++
 tb/tb_spi_display_receiver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_display_receiver_pkg.sv
// ----------------------------------------------------------------------------
// spi_display_receiver_pkg
//
// Shared definitions for the SPI display receiver: MAX7219-style register
// addresses, the expected frame length and the receive FSM state encoding.
// ----------------------------------------------------------------------------
package spi_display_receiver_pkg;

    // Register addresses carried in bits [11:8] of each frame
    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCAN      = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    // A well-formed frame carries exactly this many bits
    localparam int FRAME_LEN = 16;

    // The bit counter stops here so over-long frames stay distinguishable
    localparam logic [4:0] BIT_COUNT_MAX = 5'd17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/spi_display_receiver_input_sync.sv
// ----------------------------------------------------------------------------
// input_sync
//
// Single-bit synchronizer bringing an asynchronous pin into the clk domain.
// The reset value is chosen per pin so that no false edge appears after reset.
//
// Ports:
//   clk  - system clock
//   res  - asynchronous reset, active low
//   din  - asynchronous input pin
//   dout - synchronized copy of din, STAGES clk cycles late
// ----------------------------------------------------------------------------
module input_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic res,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/spi_display_receiver.sv
// ----------------------------------------------------------------------------
// spi_display_receiver
//
// SPI slave for the stopwatch display link. Receives 16-bit MSB-first frames,
// decodes them as MAX7219-style register writes and keeps a shadow copy of the
// digit, decode-mode and shutdown registers. Frames of the wrong length are
// counted and dropped.
//
// Ports:
//   clk         - system clock
//   res         - asynchronous reset, active low
//   sck_in      - SPI clock (idles low, data sampled on rising edge), async
//   mosi_in     - SPI data, async
//   cs_in       - chip select, active low, async
//   word_out    - last correctly framed word
//   word_valid  - one-cycle pulse when word_out updates
//   digit_data  - digit registers, digit n at [8n+7:8n]
//   decode_mode - decode-mode register
//   display_on  - shutdown register bit 0
//   frame_error - one-cycle pulse on a wrong-length frame
//   error_count - saturating count of framing errors
// ----------------------------------------------------------------------------
module spi_display_receiver
    import spi_display_receiver_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    sck_in,
    input  logic                    mosi_in,
    input  logic                    cs_in,
    output logic [15:0]             word_out,
    output logic                    word_valid,
    output logic [8*NUM_DIGITS-1:0] digit_data,
    output logic [7:0]              decode_mode,
    output logic                    display_on,
    output logic                    frame_error,
    output logic [7:0]              error_count
);

    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

    logic sck_s, mosi_s, cs_s;
    logic sck_d, cs_d;
    logic sck_rise, cs_rise, cs_fall;

    logic [FLUSH_W-1:0] flush_cnt;
    logic               flushed;
    logic               armed;

    state_t      state, next_state;
    logic        clear_frame, do_shift, commit, reject;
    logic [15:0] shift_reg;
    logic [4:0]  bit_count;
    logic [3:0]  addr;

    input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk  (clk),
        .res  (res),
        .din  (sck_in),
        .dout (sck_s)
    );

    input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk  (clk),
        .res  (res),
        .din  (mosi_in),
        .dout (mosi_s)
    );

    input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk  (clk),
        .res  (res),
        .din  (cs_in),
        .dout (cs_s)
    );

    // Delayed copies for edge detection
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sck_d <= 1'b0;
            cs_d  <= 1'b1;
        end else begin
            sck_d <= sck_s;
            cs_d  <= cs_s;
        end
    end

    // The synchronizer output shows its reset value until the real pin level
    // has propagated through. A cs that was already low at reset release would
    // otherwise look like a fresh falling edge, so a frame may only start once
    // cs has been genuinely observed high after the chain has flushed.
    assign flushed = (flush_cnt == FLUSH_W'(SYNC_STAGES));

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            if (!flushed) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (flushed && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d & armed;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A shift and a cs rise in the same cycle both take effect: the shift
    // lands on this edge and CHECK sees the updated count on the next cycle.
    always_comb begin
        next_state  = state;
        clear_frame = 1'b0;
        do_shift    = 1'b0;
        commit      = 1'b0;
        reject      = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    next_state  = SHIFT;
                    clear_frame = 1'b1;
                end
            end
            SHIFT: begin
                do_shift = sck_rise;
                if (cs_rise) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                next_state = IDLE;
                if (bit_count == 5'(FRAME_LEN)) begin
                    commit = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            shift_reg <= '0;
            bit_count <= '0;
        end else if (clear_frame) begin
            shift_reg <= '0;
            bit_count <= '0;
        end else if (do_shift) begin
            shift_reg <= {shift_reg[14:0], mosi_s};
            if (bit_count != BIT_COUNT_MAX) begin
                bit_count <= bit_count + 5'd1;
            end
        end
    end

    // The top nibble of a frame is don't-care; only [11:8] selects a register
    assign addr = shift_reg[11:8];

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            word_out    <= '0;
            word_valid  <= 1'b0;
            digit_data  <= '0;
            decode_mode <= '0;
            display_on  <= 1'b0;
            frame_error <= 1'b0;
            error_count <= '0;
        end else begin
            word_valid  <= commit;
            frame_error <= reject;
            if (commit) begin
                word_out <= shift_reg;
                case (addr)
                    ADDR_DECODE:   decode_mode <= shift_reg[7:0];
                    ADDR_SHUTDOWN: display_on  <= shift_reg[0];
                    ADDR_NOOP, ADDR_INTENSITY, ADDR_SCAN, ADDR_TEST: ;
                    default: begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (addr == ADDR_DIGIT0 + 4'(i)) begin
                                digit_data[8*i +: 8] <= shift_reg[7:0];
                            end
                        end
                    end
                endcase
            end
            if (reject && (error_count != 8'hFF)) begin
                error_count <= error_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_display_receiver.sv
// ----------------------------------------------------------------------------
// tb_spi_display_receiver
//
// Self-checking bench for spi_display_receiver. Frames are bit-banged with the
// same timing as the stopwatch master (2 clk low, 2 clk high, mosi changes
// while sck is low). Every frame pushes its expected pulse onto a scoreboard
// queue that a negedge monitor pops; register state after each frame is
// compared against a hand-built vector table.
// ----------------------------------------------------------------------------
module tb_spi_display_receiver;

    localparam int SYNC = 2;
    localparam int ND   = 8;

    logic          clk;
    logic          res;
    logic          sck_in;
    logic          mosi_in;
    logic          cs_in;
    logic [15:0]   word_out;
    logic          word_valid;
    logic [8*ND-1:0] digit_data;
    logic [7:0]    decode_mode;
    logic          display_on;
    logic          frame_error;
    logic [7:0]    error_count;

    spi_display_receiver #(.NUM_DIGITS(ND), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .res         (res),
        .sck_in      (sck_in),
        .mosi_in     (mosi_in),
        .cs_in       (cs_in),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .digit_data  (digit_data),
        .decode_mode (decode_mode),
        .display_on  (display_on),
        .frame_error (frame_error),
        .error_count (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [15:0] word;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int          nbits;
        logic [15:0] exp_word;
        logic [63:0] exp_digits;
        logic [7:0]  exp_decode;
        logic        exp_on;
        logic [7:0]  exp_errs;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[18];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pulse monitor: every word_valid / frame_error must match the oldest
    // expectation on the scoreboard.
    always @(negedge clk) begin
        if (word_valid || frame_error) begin
            compare("pulse_overlap", 64'(word_valid & frame_error), 64'd0);
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL unexpected_pulse: got word_valid=%b frame_error=%b, expected none",
                         word_valid, frame_error);
            end else begin
                exp_t e;
                e = sb.pop_front();
                compare("pulse_kind", 64'(frame_error), 64'(e.is_err));
                if (!e.is_err) begin
                    compare("word_out_at_valid", 64'(word_out), 64'(e.word));
                end
            end
        end
    end

    // cs low, then nbits MSB-first bits; leaves cs low and sck low
    task automatic drive_bits(input logic [31:0] data, input int nbits);
        @(negedge clk);
        cs_in = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi_in = data[i];
            repeat (2) @(negedge clk);
            sck_in = 1'b1;
            repeat (2) @(negedge clk);
            sck_in = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits);
        drive_bits(data, nbits);
        cs_in = 1'b1;
        repeat (SYNC + 6) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d pulses outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        e.is_err = (v.nbits != 16);
        e.word   = v.data[15:0];
        sb.push_back(e);
        send_frame(v.data, v.nbits);
        drain("pulse_missing");
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        compare($sformatf("v%0d_word_out", idx), 64'(word_out), 64'(v.exp_word));
        compare($sformatf("v%0d_digits", idx), digit_data, v.exp_digits);
        compare($sformatf("v%0d_decode", idx), 64'(decode_mode), 64'(v.exp_decode));
        compare($sformatf("v%0d_display_on", idx), 64'(display_on), 64'(v.exp_on));
        compare($sformatf("v%0d_error_count", idx), 64'(error_count), 64'(v.exp_errs));
    endtask

    task automatic check_all_zero(input string name);
        compare({name, "_regs"}, {29'd0, word_out, decode_mode, display_on, error_count,
                                  word_valid, frame_error}, 64'd0);
        compare({name, "_digits"}, digit_data, 64'd0);
    endtask

    initial begin
        exp_t e;

        vecs[0]  = '{32'h0385,    16, 16'h0385, 64'h0000_0000_0085_0000, 8'h00, 1'b1, 8'd0};
        vecs[1]  = '{32'h0A0F,    16, 16'h0A0F, 64'h0000_0000_0085_0000, 8'h00, 1'b1, 8'd0};
        vecs[2]  = '{32'h1234,    15, 16'h0A0F, 64'h0000_0000_0085_0000, 8'h00, 1'b1, 8'd1};
        vecs[3]  = '{32'h0001_0C00, 17, 16'h0A0F, 64'h0000_0000_0085_0000, 8'h00, 1'b1, 8'd2};
        vecs[4]  = '{32'h09FF,    16, 16'h09FF, 64'h0000_0000_0085_0000, 8'hFF, 1'b1, 8'd2};
        vecs[5]  = '{32'h0105,    16, 16'h0105, 64'h0000_0000_0085_0005, 8'hFF, 1'b1, 8'd2};
        vecs[6]  = '{32'h0204,    16, 16'h0204, 64'h0000_0000_0085_0405, 8'hFF, 1'b1, 8'd2};
        vecs[7]  = '{32'h0383,    16, 16'h0383, 64'h0000_0000_0083_0405, 8'hFF, 1'b1, 8'd2};
        vecs[8]  = '{32'h0402,    16, 16'h0402, 64'h0000_0000_0283_0405, 8'hFF, 1'b1, 8'd2};
        vecs[9]  = '{32'h0581,    16, 16'h0581, 64'h0000_0081_0283_0405, 8'hFF, 1'b1, 8'd2};
        vecs[10] = '{32'h0600,    16, 16'h0600, 64'h0000_0081_0283_0405, 8'hFF, 1'b1, 8'd2};
        vecs[11] = '{32'h0C00,    16, 16'h0C00, 64'h0000_0081_0283_0405, 8'hFF, 1'b0, 8'd2};
        vecs[12] = '{32'hF80A,    16, 16'hF80A, 64'h0A00_0081_0283_0405, 8'hFF, 1'b0, 8'd2};
        vecs[13] = '{32'h0011,    16, 16'h0011, 64'h0A00_0081_0283_0405, 8'hFF, 1'b0, 8'd2};
        vecs[14] = '{32'h0B07,    16, 16'h0B07, 64'h0A00_0081_0283_0405, 8'hFF, 1'b0, 8'd2};
        vecs[15] = '{32'h0F01,    16, 16'h0F01, 64'h0A00_0081_0283_0405, 8'hFF, 1'b0, 8'd2};
        vecs[16] = '{32'h0000,     0, 16'h0F01, 64'h0A00_0081_0283_0405, 8'hFF, 1'b0, 8'd3};
        vecs[17] = '{32'h0C01,    16, 16'h0C01, 64'h0A00_0081_0283_0405, 8'hFF, 1'b1, 8'd3};

        // Reset with random pin activity
        res     = 1'b0;
        sck_in  = 1'b0;
        mosi_in = 1'b0;
        cs_in   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sck_in  = 1'($urandom_range(0, 1));
            mosi_in = 1'($urandom_range(0, 1));
            cs_in   = 1'($urandom_range(0, 1));
            check_all_zero("reset_hold");
        end

        // Release with cs already low; sck toggling must be ignored
        @(negedge clk);
        cs_in  = 1'b0;
        sck_in = 1'b0;
        @(negedge clk);
        res = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mosi_in = 1'($urandom_range(0, 1));
            repeat (2) @(negedge clk);
            sck_in = 1'b1;
            repeat (2) @(negedge clk);
            sck_in = 1'b0;
        end
        repeat (4) @(negedge clk);
        cs_in = 1'b1;
        repeat (SYNC + 8) @(negedge clk);
        check_all_zero("release_cs_low");

        // First frame with exact latency check
        e.is_err = 1'b0;
        e.word   = 16'h0C01;
        sb.push_back(e);
        drive_bits(32'h0C01, 16);
        cs_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        compare("latency_e0", 64'(word_valid), 64'd0);
        for (int k = 1; k <= SYNC; k++) begin
            @(negedge clk);
            compare($sformatf("latency_e%0d", k), 64'(word_valid), 64'd0);
        end
        @(negedge clk);
        compare("latency_pulse", 64'(word_valid), 64'd1);
        @(negedge clk);
        compare("latency_one_cycle", 64'(word_valid), 64'd0);
        compare("first_word_out", 64'(word_out), 64'h0C01);
        compare("first_display_on", 64'(display_on), 64'd1);
        repeat (4) @(negedge clk);
        drain("first_pulse_missing");

        // Table-driven register writes and framing errors
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // sck activity while idle is ignored
        for (int i = 0; i < 6; i++) begin
            mosi_in = 1'($urandom_range(0, 1));
            repeat (2) @(negedge clk);
            sck_in = 1'b1;
            repeat (2) @(negedge clk);
            sck_in = 1'b0;
        end
        repeat (SYNC + 6) @(negedge clk);
        checkOutput(vecs[17], 100);

        // Error counter saturation
        e.is_err = 1'b1;
        e.word   = 16'h0000;
        for (int i = 0; i < 300; i++) begin
            sb.push_back(e);
            send_frame(32'h0, 0);
        end
        drain("bad_frames_missing");
        compare("error_count_saturated", 64'(error_count), 64'd255);
        compare("saturate_word_out", 64'(word_out), 64'h0C01);
        compare("saturate_digits", digit_data, 64'h0A00_0081_0283_0405);

        // Reset mid-frame with cs held low
        drive_bits(32'h00AB, 8);
        res = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("midframe_reset");
        res = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mosi_in = 1'($urandom_range(0, 1));
            repeat (2) @(negedge clk);
            sck_in = 1'b1;
            repeat (2) @(negedge clk);
            sck_in = 1'b0;
        end
        repeat (2) @(negedge clk);
        cs_in = 1'b1;
        repeat (SYNC + 8) @(negedge clk);
        check_all_zero("post_reset_cs_rise");

        e.is_err = 1'b0;
        e.word   = 16'h0107;
        sb.push_back(e);
        send_frame(32'h0107, 16);
        drain("post_reset_frame_missing");
        compare("post_reset_word_out", 64'(word_out), 64'h0107);
        compare("post_reset_digits", digit_data, 64'h0000_0000_0000_0007);
        compare("post_reset_errors", 64'(error_count), 64'd0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
